fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 41 ++++
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg : shared instruction-length, FSM and reset types, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    CYCLE5  = 2'd0,
    CYCLE7  = 2'd1,
    CYCLE12 = 2'd2
  } instr_length;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_IRQ   = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  localparam logic [12:0] RESET_VECTOR = 13'h0100;
  localparam logic [11:0] NOP5_OPCODE  = 12'hFFB;
  localparam logic [4:0]  IRQ_TICKS    = 5'd24;

  // Two clk_2x_en ticks per oscillator cycle.
  function automatic logic [4:0] instr_ticks(input instr_length len);
    logic [4:0] ticks;
    ticks = 5'd10;
    case (len)
      CYCLE5:  ticks = 5'd10;
      CYCLE7:  ticks = 5'd14;
      CYCLE12: ticks = 5'd24;
      default: ticks = 5'd10;
    endcase
    return ticks;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer : fetch/latch/exec sequencer with IRQ entry and HALT, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_2x_en,
  input  instr_length cycle_length,
  input  logic        skip_pc_increment,
  input  logic        disable_interrupt,
  input  logic        pc_load,
  input  logic [12:0] pc_load_addr,
  input  logic        halt_req,
  input  logic        wake,
  input  logic        irq_pending,
  output logic [12:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] opcode,
  output logic        opcode_valid,
  output logic        irq_take,
  output logic [12:0] pc
);

  fetch_state_t state;
  logic [4:0]   count;
  logic [4:0]   last_tick;
  logic         inhibit;
  logic         load_held;
  logic [12:0]  load_addr;

  logic         load_now;
  logic [12:0]  load_target;
  logic [12:0]  boundary_pc;
  logic         at_boundary;

  assign rom_addr = pc;

  // A jump request on the boundary tick itself still counts, newest target wins.
  always_comb begin
    load_now    = load_held | pc_load;
    load_target = pc_load ? pc_load_addr : load_addr;
    boundary_pc = pc;
    if (load_now)
      boundary_pc = load_target;
    else if (!skip_pc_increment)
      boundary_pc = {pc[12], pc[11:0] + 12'd1};
    at_boundary = (count != 5'd0) && (count == last_tick);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_FETCH;
      pc           <= RESET_VECTOR;
      opcode       <= NOP5_OPCODE;
      opcode_valid <= 1'b0;
      irq_take     <= 1'b0;
      count        <= 5'd0;
      last_tick    <= 5'd0;
      inhibit      <= 1'b0;
      load_held    <= 1'b0;
      load_addr    <= 13'd0;
    end else if (clk_2x_en) begin
      opcode_valid <= 1'b0;
      irq_take     <= 1'b0;
      case (state)
        ST_FETCH: begin
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          opcode       <= rom_data;
          opcode_valid <= 1'b1;
          count        <= 5'd0;
          state        <= ST_EXEC;
        end
        ST_EXEC: begin
          count <= count + 5'd1;
          // First EXEC tick: decode outputs are valid; FETCH+LATCH already used two ticks.
          if (count == 5'd0) begin
            last_tick <= instr_ticks(cycle_length) - 5'd3;
            inhibit   <= disable_interrupt;
          end
          if (pc_load) begin
            load_held <= 1'b1;
            load_addr <= pc_load_addr;
          end
          if (at_boundary) begin
            pc        <= boundary_pc;
            load_held <= 1'b0;
            inhibit   <= 1'b0;
            count     <= 5'd0;
            if (irq_pending && !inhibit) begin
              state    <= ST_IRQ;
              irq_take <= 1'b1;
            end else if (halt_req) begin
              state <= ST_HALT;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_IRQ: begin
          count <= count + 5'd1;
          if (pc_load) begin
            load_held <= 1'b1;
            load_addr <= pc_load_addr;
          end
          if (count == IRQ_TICKS - 5'd1) begin
            if (load_now)
              pc <= load_target;
            load_held <= 1'b0;
            count     <= 5'd0;
            state     <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (irq_pending) begin
            state    <= ST_IRQ;
            irq_take <= 1'b1;
            count    <= 5'd0;
          end else if (wake) begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed + randomized bench with instruction-level model, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_2x_en = 1'b0;
  instr_length cycle_length = CYCLE5;
  logic        skip_pc_increment = 1'b0;
  logic        disable_interrupt = 1'b0;
  logic        pc_load = 1'b0;
  logic [12:0] pc_load_addr = 13'd0;
  logic        halt_req = 1'b0;
  logic        wake = 1'b0;
  logic        irq_pending = 1'b0;
  logic [12:0] rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic [11:0] opcode;
  logic        opcode_valid;
  logic        irq_take;
  logic [12:0] pc;

  fetch_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .clk_2x_en         (clk_2x_en),
    .cycle_length      (cycle_length),
    .skip_pc_increment (skip_pc_increment),
    .disable_interrupt (disable_interrupt),
    .pc_load           (pc_load),
    .pc_load_addr      (pc_load_addr),
    .halt_req          (halt_req),
    .wake              (wake),
    .irq_pending       (irq_pending),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .opcode            (opcode),
    .opcode_valid      (opcode_valid),
    .irq_take          (irq_take),
    .pc                (pc)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [0:8191];

  always @(posedge clk) begin
    if (clk_2x_en)
      rom_data <= rom[rom_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: activity kind + tick position within it.
  localparam int MD_INSTR = 0;
  localparam int MD_IRQ   = 1;
  localparam int MD_HALT  = 2;

  int          m_mode;
  int          m_t;
  int          m_len;
  bit          m_inh;
  bit          m_ld;
  logic [12:0] m_lda;
  logic [12:0] m_pc;
  logic [11:0] m_op;
  bit          m_ov;
  bit          m_it;

  function automatic int osc_cycles(input instr_length l);
    int n;
    n = 5;
    if (l == CYCLE7)  n = 7;
    if (l == CYCLE12) n = 12;
    return n;
  endfunction

  task automatic model_reset();
    m_mode = MD_INSTR; m_t = 0; m_len = 10; m_inh = 0; m_ld = 0; m_lda = 13'd0;
    m_pc = 13'h0100; m_op = 12'hFFB; m_ov = 0; m_it = 0;
  endtask

  task automatic model_tick();
    m_ov = 0;
    m_it = 0;
    if (m_mode == MD_INSTR) begin
      if (m_t == 1) begin
        m_op = rom[m_pc];
        m_ov = 1;
      end
      if (m_t == 2) begin
        m_len = 2 * osc_cycles(cycle_length);
        m_inh = disable_interrupt;
      end
      if (m_t >= 2 && pc_load) begin
        m_ld  = 1;
        m_lda = pc_load_addr;
      end
      if (m_t >= 2 && m_t == m_len - 1) begin
        if (m_ld) m_pc = m_lda;
        else if (!skip_pc_increment) m_pc = {m_pc[12], m_pc[11:0] + 12'd1};
        if (irq_pending && !m_inh) begin
          m_mode = MD_IRQ;
          m_it = 1;
        end else if (halt_req) begin
          m_mode = MD_HALT;
        end
        m_ld = 0;
        m_inh = 0;
        m_t = 0;
      end else begin
        m_t++;
      end
    end else if (m_mode == MD_IRQ) begin
      if (pc_load) begin
        m_ld  = 1;
        m_lda = pc_load_addr;
      end
      if (m_t == 23) begin
        if (m_ld) m_pc = m_lda;
        m_ld = 0;
        m_mode = MD_INSTR;
        m_t = 0;
      end else begin
        m_t++;
      end
    end else begin
      if (irq_pending) begin
        m_mode = MD_IRQ;
        m_it = 1;
        m_t = 0;
      end else if (wake) begin
        m_mode = MD_INSTR;
        m_t = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else if (clk_2x_en) model_tick();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check_eq("pc",       32'(pc),           32'(m_pc));
        check_eq("rom_addr", 32'(rom_addr),     32'(m_pc));
        check_eq("opcode",   32'(opcode),       32'(m_op));
        check_eq("op_valid", 32'(opcode_valid), 32'(m_ov));
        check_eq("irq_take", 32'(irq_take),     32'(m_it));
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  int changes;

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 12'($urandom);
    rom[13'h0100] = 12'h0FF;

    ticks(2);
    check_eq("rst_pc",     32'(pc),           32'h0100);
    check_eq("rst_opcode", 32'(opcode),       32'hFFB);
    check_eq("rst_ov",     32'(opcode_valid), 32'h0);

    // Reset release, NOP-length first instruction.
    clk_2x_en = 1'b1;
    reset_n   = 1'b1;
    ticks(1);
    check_eq("first_fetch_addr", 32'(rom_addr), 32'h0100);
    check_eq("tick0_ov", 32'(opcode_valid), 32'h0);
    ticks(1);
    check_eq("tick1_ov", 32'(opcode_valid), 32'h1);
    check_eq("tick1_op", 32'(opcode), 32'h0FF);
    ticks(7);
    check_eq("pre_boundary_pc", 32'(pc), 32'h0100);
    ticks(1);
    check_eq("fetch_101", 32'(rom_addr), 32'h0101);

    // Jump to 0x0FFF, then CYCLE7 wraps the page/step field.
    pc_load = 1'b1; pc_load_addr = 13'h0FFF;
    ticks(3);
    pc_load = 1'b0;
    ticks(7);
    check_eq("load_0fff", 32'(pc), 32'h0FFF);
    cycle_length = CYCLE7;
    ticks(13);
    check_eq("c7_hold", 32'(pc), 32'h0FFF);
    ticks(1);
    check_eq("c7_wrap", 32'(pc), 32'h0000);

    // Load beats skip on a CYCLE12 instruction.
    cycle_length = CYCLE12; skip_pc_increment = 1'b1;
    pc_load = 1'b1; pc_load_addr = 13'h1234;
    ticks(23);
    check_eq("c12_hold", 32'(pc), 32'h0000);
    ticks(1);
    check_eq("c12_load", 32'(pc), 32'h1234);
    pc_load = 1'b0; skip_pc_increment = 1'b0;

    // Interrupt inhibited for exactly one boundary.
    cycle_length = CYCLE5; disable_interrupt = 1'b1; irq_pending = 1'b1;
    ticks(3);
    disable_interrupt = 1'b0;
    ticks(7);
    check_eq("pset_no_irq", 32'(irq_take), 32'h0);
    check_eq("pset_pc", 32'(pc), 32'h1235);
    ticks(10);
    check_eq("irq_taken", 32'(irq_take), 32'h1);
    check_eq("irq_pc", 32'(pc), 32'h1236);
    irq_pending = 1'b0;
    pc_load = 1'b1; pc_load_addr = 13'h0200;
    ticks(23);
    check_eq("irq_hold_pc", 32'(pc), 32'h1236);
    ticks(1);
    check_eq("irq_end_load", 32'(pc), 32'h0200);
    pc_load = 1'b0;

    // HALT at boundary, then wake.
    halt_req = 1'b1;
    ticks(10);
    check_eq("halt_pc", 32'(pc), 32'h0201);
    halt_req = 1'b0;
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      ticks(1);
      if (rom_addr !== 13'h0201) changes++;
    end
    check_eq("halt_no_change", 32'(changes), 32'h0);
    wake = 1'b1;
    ticks(1);
    wake = 1'b0;
    check_eq("wake_fetch", 32'(rom_addr), 32'h0201);
    ticks(2);
    check_eq("wake_op", 32'(opcode), 32'(rom[13'h0201]));
    check_eq("wake_ov", 32'(opcode_valid), 32'h1);

    // Asynchronous reset mid-EXEC without a tick enable.
    ticks(2);
    clk_2x_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_pc", 32'(pc), 32'h0100);
    check_eq("async_op", 32'(opcode), 32'hFFB);
    check_eq("async_ov", 32'(opcode_valid), 32'h0);
    check_eq("async_it", 32'(irq_take), 32'h0);
    ticks(2);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      clk_2x_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       cycle_length = CYCLE5;
        1:       cycle_length = CYCLE7;
        default: cycle_length = CYCLE12;
      endcase
      skip_pc_increment = ($urandom_range(0, 3) == 0);
      disable_interrupt = ($urandom_range(0, 3) == 0);
      pc_load           = ($urandom_range(0, 7) == 0);
      pc_load_addr      = 13'($urandom);
      halt_req          = ($urandom_range(0, 15) == 0);
      wake              = ($urandom_range(0, 7) == 0);
      irq_pending       = ($urandom_range(0, 11) == 0);
      reset_n           = (i != 2000);
      ticks(1);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
